// File: rtl/rr_arb8_sched.sv
// ============================================================================
//  Module      : rr_arb8_sched
//  Description : Eight-way round-robin scheduler with a one-hot grant decode,
//                a mandatory one-cycle turnaround between owners and an
//                optional hold-time limit with lockable preemption.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb8_sched #(
    parameter int HOLD_MAX = 0
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       lock,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam logic       c_timeout_en = (HOLD_MAX != 0);
    localparam logic [7:0] c_hold_thr   = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

    state_t     r_state;
    logic [2:0] r_last;
    logic [2:0] r_gnt_idx;
    logic [7:0] r_gnt;
    logic [7:0] r_hold_cnt;
    logic       r_gnt_valid;
    logic       r_preempt;
    logic       r_busy;

    logic [2:0] w_win_idx;
    logic [2:0] w_cand;
    logic       w_found;
    logic [7:0] w_win_oh;
    logic [7:0] w_owner_oh;
    logic       w_any_req;
    logic       w_release;
    logic       w_at_limit;
    logic       w_others;
    logic       w_preempt;

    // Rotating scan: last+1 first, previous owner considered last.
    always_comb begin
        w_win_idx = r_last;
        w_cand    = r_last;
        w_found   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            w_cand = r_last + 3'(k);
            if (!w_found && req[w_cand]) begin
                w_win_idx = w_cand;
                w_found   = 1'b1;
            end
        end
    end

    generate
        for (genvar n = 0; n < 8; n++) begin : g_onehot
            assign w_win_oh[n]   = (w_win_idx == 3'(n));
            assign w_owner_oh[n] = (r_gnt_idx == 3'(n));
        end
    endgenerate

    assign w_any_req  = |req;
    assign w_release  = ~req[r_gnt_idx];
    assign w_at_limit = c_timeout_en && (r_hold_cnt == c_hold_thr);
    assign w_others   = |(req & ~w_owner_oh);
    // Voluntary release takes precedence, so a coincident timeout never flags.
    assign w_preempt  = w_at_limit && !lock && w_others && !w_release;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_last      <= 3'd7;
            r_gnt_idx   <= 3'd0;
            r_gnt       <= 8'd0;
            r_hold_cnt  <= 8'd0;
            r_gnt_valid <= 1'b0;
            r_preempt   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_preempt <= 1'b0;
                    if (w_any_req) begin
                        r_state     <= ST_GRANT;
                        r_gnt_idx   <= w_win_idx;
                        r_last      <= w_win_idx;
                        r_gnt       <= w_win_oh;
                        r_gnt_valid <= 1'b1;
                        r_hold_cnt  <= 8'd0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (w_release || w_preempt) begin
                        r_state     <= ST_TURN;
                        r_gnt       <= 8'd0;
                        r_gnt_valid <= 1'b0;
                        r_preempt   <= w_preempt;
                    end else if (!w_at_limit && (r_hold_cnt != 8'hFF)) begin
                        // Pinned at the threshold so a later lock drop or a new
                        // requester can still trigger preemption.
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                ST_TURN: begin
                    r_preempt <= 1'b0;
                    if (w_any_req) begin
                        r_state     <= ST_GRANT;
                        r_gnt_idx   <= w_win_idx;
                        r_last      <= w_win_idx;
                        r_gnt       <= w_win_oh;
                        r_gnt_valid <= 1'b1;
                        r_hold_cnt  <= 8'd0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_gnt       <= 8'd0;
                    r_gnt_valid <= 1'b0;
                    r_preempt   <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign preempt   = r_preempt;
    assign busy      = r_busy;

endmodule

`default_nettype wire
